// File: rtl/slave_split_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : slave_split_ctrl
//  Purpose  : Slave-side split-transaction sequencer. Launches the slave
//             core, finishes fast operations on the bus, and splits (frees
//             the bus) when the core is slow. Once the core is done it drops
//             the split line, waits for the controller's ack, then starts
//             the response.
//  Options  : SPLIT_TIMEOUT_EN - if defined, a split-phase watchdog forces
//             completion after TIMEOUT_CYC cycles and sets the sticky
//             timeout_err flag.
//  Revision : 1.0 - initial release
// ============================================================================
module slave_split_ctrl #(
    parameter int SPLIT_THRESH = 8,     // 1..255
    parameter int MIN_SPLIT    = 2,     // >= 1
    parameter int TIMEOUT_CYC  = 1023   // used only with SPLIT_TIMEOUT_EN
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_valid,
    output logic       core_start,
    input  logic       core_done,
    output logic       split_o,
    input  logic       split_ack_i,
    input  logic       bus_util,
    output logic       hold_bus,
    output logic       resp_start,
    input  logic       resp_done,
    output logic       split_active,
    output logic       timeout_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_CORE   = 3'd1,
        S_SPLIT_ENTER = 3'd2,
        S_SPLIT_WAIT  = 3'd3,
        S_SPLIT_DONE  = 3'd4,
        S_WAIT_ACK    = 3'd5,
        S_RESPOND     = 3'd6,
        S_RESP_WAIT   = 3'd7
    } state_t;

    // Min-hold counter holds the number of further cycles split_o must stay
    // high after the current one; it is loaded as split_o rises.
    localparam int            HW_W          = (MIN_SPLIT > 1) ? $clog2(MIN_SPLIT) : 1;
    localparam logic [HW_W-1:0] C_HOLD_LOAD = HW_W'(MIN_SPLIT - 1);
    localparam logic [7:0]    C_THRESH_LAST = 8'(SPLIT_THRESH - 1);

    state_t          state_q;
    logic [7:0]      cnt_q;
    logic [HW_W-1:0] hold_cnt_q;
    logic            done_q;
    logic            core_start_q;
    logic            split_o_q;
    logic            hold_bus_q;
    logic            resp_start_q;
    logic            split_active_q;

    logic            w_tmo_hit;
    logic            w_done_now;
    logic            w_hold_ok;

    // The bus line is informational only: the split path never waits on it.
    logic            w_unused_bus_util;
    assign w_unused_bus_util = bus_util;

`ifdef SPLIT_TIMEOUT_EN
    localparam int            TW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          timeout_err_q;

    // Watchdog fires on the TIMEOUT_CYC-th SPLIT_WAIT cycle without a done;
    // a real done in that same cycle takes precedence.
    assign w_tmo_hit = (state_q == S_SPLIT_WAIT) && !done_q && !core_done &&
                       (tmo_cnt_q == C_TMO_LAST);

    // Split-phase watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q != S_SPLIT_WAIT) begin
                tmo_cnt_q <= '0;
            end else if (!done_q) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (w_tmo_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYC;
    assign w_tmo_hit    = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    // A timeout counts as a completion so the normal ack/response path runs.
    assign w_done_now = done_q | core_done | w_tmo_hit;
    assign w_hold_ok  = (hold_cnt_q == '0);

    // Main sequencer: state, counters, done latch and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            hold_cnt_q     <= '0;
            done_q         <= 1'b0;
            core_start_q   <= 1'b0;
            split_o_q      <= 1'b0;
            hold_bus_q     <= 1'b0;
            resp_start_q   <= 1'b0;
            split_active_q <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            resp_start_q <= 1'b0;
            if (hold_cnt_q != '0) begin
                hold_cnt_q <= hold_cnt_q - 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        core_start_q <= 1'b1;
                        hold_bus_q   <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= S_WAIT_CORE;
                    end
                end
                S_WAIT_CORE: begin
                    cnt_q <= cnt_q + 8'd1;
                    // A done on the threshold cycle wins: no split.
                    if (core_done) begin
                        resp_start_q <= 1'b1;
                        state_q      <= S_RESPOND;
                    end else if (cnt_q == C_THRESH_LAST) begin
                        // Release the bus regardless of bus_util.
                        split_o_q      <= 1'b1;
                        hold_bus_q     <= 1'b0;
                        split_active_q <= 1'b1;
                        hold_cnt_q     <= C_HOLD_LOAD;
                        state_q        <= S_SPLIT_ENTER;
                    end
                end
                S_SPLIT_ENTER: begin
                    done_q  <= 1'b0;
                    state_q <= S_SPLIT_WAIT;
                end
                S_SPLIT_WAIT: begin
                    if (w_done_now && w_hold_ok) begin
                        split_o_q <= 1'b0;
                        done_q    <= 1'b0;
                        state_q   <= S_SPLIT_DONE;
                    end else if (core_done || w_tmo_hit) begin
                        done_q <= 1'b1;
                    end
                end
                S_SPLIT_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (split_ack_i) begin
                        hold_bus_q     <= 1'b1;
                        split_active_q <= 1'b0;
                        resp_start_q   <= 1'b1;
                        state_q        <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    state_q <= S_RESP_WAIT;
                end
                S_RESP_WAIT: begin
                    if (resp_done) begin
                        hold_bus_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign core_start   = core_start_q;
    assign split_o      = split_o_q;
    assign hold_bus     = hold_bus_q;
    assign resp_start   = resp_start_q;
    assign split_active = split_active_q;
    assign state        = state_q;

endmodule
`default_nettype wire
